// File: rtl/fcs_check.sv
// ---------------------------------------------------------------------------
// fcs_check
//
// Receive-side Ethernet frame check sequence checker for an RMII dibit
// stream. It sits between the RMII receive deframer and the packet parser.
//
// Incoming dibits are held back by 16 positions, so the trailing 32-bit FCS
// never reaches the output. CRC-32/BZIP2 is computed over the forwarded
// payload. At end of frame, that CRC is compared against the FCS still held
// in the delay line.
//
// Ports:
//   clk         system clock, at most one dibit per cycle
//   rst         asynchronous, active-low reset
//   axiiv       input valid, high for the whole frame, low between frames
//   axiid[1:0]  input dibit, axiid[0] is the earlier bit on the wire
//   axiov       payload dibit valid
//   axiod[1:0]  payload dibit, same bit order as axiid
//   done        one-cycle pulse at end of every frame
//   ok          verdict qualified by done (FCS match and whole bytes)
//   good_count  frames with ok = 1 (only with FCS_CHECK_STATS_EN)
//   bad_count   frames with ok = 0 (only with FCS_CHECK_STATS_EN)
//
// Build option:
//   FCS_CHECK_STATS_EN  adds the saturating good/bad frame counters
// ---------------------------------------------------------------------------
module fcs_check (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       done,
  output logic       ok
`ifdef FCS_CHECK_STATS_EN
  ,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    STREAM  = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [12:0] N_MAX    = 13'h1FFF;
  localparam logic [12:0] N_FULL   = 13'd16;

  state_t            state_q, state_d;
  logic [15:0][1:0]  sr_q, sr_d;
  logic [31:0]       crc_q, crc_d;
  logic [12:0]       n_q, n_d;
  logic              prev_valid_q, prev_valid_d;
  logic              axiov_q, axiov_d;
  logic [1:0]        axiod_q, axiod_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;

  logic [15:0][1:0]  sr_shift;
  logic [12:0]       n_inc;
  logic [31:0]       fcs_word;
  logic              verdict;

  // Two MSB-first CRC steps; d[0] is the earlier wire bit, so it goes first.
  function automatic logic [31:0] crc_step2(input logic [31:0] c,
                                            input logic [1:0]  d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[31] ^ d[i]) begin
        r = {r[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        r = {r[30:0], 1'b0};
      end
    end
    return r;
  endfunction

  // The newest dibit enters at index 0, so sr_q[15] is always the oldest entry.
  assign sr_shift = {sr_q[14:0], axiid};

  // Saturate at 8191 so over-long frames cannot wrap back into a "valid" length.
  assign n_inc = (n_q == N_MAX) ? n_q : n_q + 13'd1;

  // Reassemble the FCS from the delay line, oldest dibit carrying bit 31.
  always_comb begin
    fcs_word = '0;
    for (int k = 0; k < 16; k++) begin
      fcs_word[31 - 2*k] = sr_q[15 - k][0];
      fcs_word[30 - 2*k] = sr_q[15 - k][1];
    end
  end

  // A runt has n < 16, so it fails here without any special case.
  assign verdict = (fcs_word == ~crc_q) && (n_q >= N_FULL) && (n_q[1:0] == 2'b00);

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    crc_d        = crc_q;
    n_d          = n_q;
    prev_valid_d = axiiv;
    axiov_d      = 1'b0;
    axiod_d      = 2'b00;
    done_d       = 1'b0;
    ok_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // prev_valid_q comes out of reset set, so a frame already in flight
        // when reset is released is sent to DISCARD and is not taken as a start.
        if (axiiv) begin
          if (prev_valid_q) begin
            state_d = DISCARD;
          end else begin
            sr_d    = sr_shift;
            n_d     = 13'd1;
            state_d = FILL;
          end
        end
      end

      FILL: begin
        if (axiiv) begin
          sr_d = sr_shift;
          n_d  = n_inc;
          if (n_q == 13'd15) begin
            state_d = STREAM;
          end
        end else begin
          done_d  = 1'b1;
          ok_d    = verdict;
          crc_d   = CRC_INIT;
          n_d     = '0;
          state_d = IDLE;
        end
      end

      STREAM: begin
        if (axiiv) begin
          sr_d    = sr_shift;
          n_d     = n_inc;
          axiov_d = 1'b1;
          axiod_d = sr_q[15];
          crc_d   = crc_step2(crc_q, sr_q[15]);
        end else begin
          done_d  = 1'b1;
          ok_d    = verdict;
          crc_d   = CRC_INIT;
          n_d     = '0;
          state_d = IDLE;
        end
      end

      DISCARD: begin
        if (!axiiv) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      crc_q        <= CRC_INIT;
      n_q          <= '0;
      prev_valid_q <= 1'b1;
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      crc_q        <= crc_d;
      n_q          <= n_d;
      prev_valid_q <= prev_valid_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
    end
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;
  assign done  = done_q;
  assign ok    = ok_q;

`ifdef FCS_CHECK_STATS_EN
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;

  // The counters update on the same edge that registers done, so they already
  // include the current frame while done is high.
  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (done_d) begin
      if (ok_d) begin
        if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
      end else begin
        if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign good_count = good_q;
  assign bad_count  = bad_q;
`else
  // This build has no frame statistics counters.
`endif

endmodule

// File: tb/tb_fcs_check.sv
// ---------------------------------------------------------------------------
// tb_fcs_check
//
// Self-checking bench for fcs_check. Each frame is built as a dibit queue.
// When a frame is driven, its expected payload dibits and its expected
// verdict are pushed to scoreboards. A monitor on the falling clock edge pops
// and compares them whenever the DUT raises axiov or done.
// ---------------------------------------------------------------------------
module tb_fcs_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       axiiv;
  logic [1:0] axiid;
  logic       axiov;
  logic [1:0] axiod;
  logic       done;
  logic       ok;
`ifdef FCS_CHECK_STATS_EN
  logic [15:0] good_count;
  logic [15:0] bad_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0] tx_q[$];
  logic [1:0] exp_q[$];
  bit         verd_q[$];
  bit         pay_q[$];
  int         exp_good = 0;
  int         exp_bad  = 0;

  logic [1:0] mon_exp;
  bit         mon_ok;
  bit         mon_pay;
  logic       prev_axiov = 1'b0;

  always #5 clk = ~clk;

  fcs_check dut (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .axiov      (axiov),
    .axiod      (axiod),
    .done       (done),
    .ok         (ok)
`ifdef FCS_CHECK_STATS_EN
    ,
    .good_count (good_count),
    .bad_count  (bad_count)
`endif
  );

  // Scoreboard monitor: compares payload and verdicts as the DUT produces them.
  always @(negedge clk) begin
    if (axiov === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL payload_extra: got axiod=%0d, required no payload", axiod);
      end else begin
        mon_exp = exp_q.pop_front();
        if (axiod !== mon_exp) begin
          errors++;
          $display("[TB] FAIL payload_data: got %0d, required %0d", axiod, mon_exp);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (verd_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL done_extra: got done=1, required no done");
      end else begin
        mon_ok  = verd_q.pop_front();
        mon_pay = pay_q.pop_front();
        if (ok !== mon_ok) begin
          errors++;
          $display("[TB] FAIL verdict: got ok=%0b, required %0b", ok, mon_ok);
        end
        checks++;
        if (prev_axiov !== mon_pay) begin
          errors++;
          $display("[TB] FAIL done_timing: axiov before done=%0b, required %0b", prev_axiov, mon_pay);
        end
      end
      checks++;
      if (axiov !== 1'b0) begin
        errors++;
        $display("[TB] FAIL axiov_with_done: got axiov=%0b, required 0", axiov);
      end
    end
    prev_axiov = axiov;
  end

  // Global watchdog: a hang is reported as a failure.
  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Wire order: bit 7 then bit 6 in the first dibit, and so on.
  task automatic add_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) tx_q.push_back({b[2*i], b[2*i+1]});
  endtask

  task automatic add_fcs(input logic [31:0] f);
    for (int k = 0; k < 16; k++) tx_q.push_back({f[30-2*k], f[31-2*k]});
  endtask

  // Bit-serial CRC-32/BZIP2 reference over the first cnt dibits of tx_q.
  function automatic logic [31:0] model_crc(input int cnt);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      for (int b = 0; b < 2; b++) begin
        fb = c[31] ^ tx_q[i][b];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    end
    return ~c;
  endfunction

  // Pushes the expected payload and verdict for tx_q. want = -1 uses the model.
  task automatic expect_frame(input int want);
    int          n;
    int          nsat;
    int          p;
    logic [31:0] f;
    bit          v;
    n    = tx_q.size();
    nsat = (n > 8191) ? 8191 : n;
    p    = (n > 16) ? n - 16 : 0;
    for (int i = 0; i < p; i++) exp_q.push_back(tx_q[i]);
    f = '0;
    if (n >= 16) begin
      for (int k = 0; k < 16; k++) begin
        f[31-2*k] = tx_q[n-16+k][0];
        f[30-2*k] = tx_q[n-16+k][1];
      end
    end
    v = (n >= 16) && ((nsat % 4) == 0) && (f == model_crc(p));
    if (want >= 0) v = (want != 0);
    verd_q.push_back(v);
    pay_q.push_back(p > 0);
    if (v) exp_good++; else exp_bad++;
  endtask

  task automatic drive_frame(input int want, input int gap);
    expect_frame(want);
    foreach (tx_q[i]) begin
      @(negedge clk);
      axiiv = 1'b1;
      axiid = tx_q[i];
    end
    @(negedge clk);
    axiiv = 1'b0;
    axiid = 2'b00;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_drain(output bit timed_out);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || verd_q.size() != 0) && i < 60) begin
      @(negedge clk);
      i++;
    end
    timed_out = (exp_q.size() != 0 || verd_q.size() != 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic build_good();
    string s;
    s = "123456789";
    tx_q.delete();
    for (int i = 0; i < s.len(); i++) add_byte(s[i]);
    add_fcs(32'hFC891918);
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    axiiv = 1'b0;
    axiid = 2'b00;
    #12;
    checks++;
    if ({axiov, axiod, done, ok} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, required 00000", {axiov, axiod, done, ok});
    end
`ifdef FCS_CHECK_STATS_EN
    checks++;
    if ({good_count, bad_count} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_counts: got %0d/%0d, required 0/0", good_count, bad_count);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    bit to;
    build_good();
    drive_frame(1, 2);
    wait_drain(to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL good_frame_drain: got pending=%0d, required 0", exp_q.size() + verd_q.size());
    end
  endtask

  task automatic test_bad_fcs();
    bit to;
    build_good();
    tx_q[tx_q.size()-1] = tx_q[tx_q.size()-1] ^ 2'b11;
    drive_frame(0, 2);
    wait_drain(to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL bad_fcs_drain: got pending=%0d, required 0", exp_q.size() + verd_q.size());
    end
  endtask

  task automatic test_runt();
    bit to;
    tx_q.delete();
    for (int i = 0; i < 10; i++) tx_q.push_back(2'($urandom_range(0, 3)));
    drive_frame(0, 2);
    wait_drain(to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL runt_drain: got pending=%0d, required 0", exp_q.size() + verd_q.size());
    end
  endtask

  task automatic test_misaligned();
    bit to;
    string s;
    s = "123456789";
    tx_q.delete();
    for (int i = 0; i < s.len(); i++) add_byte(s[i]);
    tx_q.push_back(2'b01);
    add_fcs(32'hFC891918);
    drive_frame(0, 2);
    wait_drain(to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL misaligned_drain: got pending=%0d, required 0", exp_q.size() + verd_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    build_good();
    drive_frame(1, 1);
    build_good();
    drive_frame(1, 2);
    wait_drain(to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL back_to_back_drain: got pending=%0d, required 0", exp_q.size() + verd_q.size());
    end
  endtask

  // Random payloads, including zero bytes (exactly 16 dibits, boundary case).
  task automatic test_random_frames();
    bit to;
    int lens[4] = '{0, 1, 5, 20};
    for (int t = 0; t < 8; t++) begin
      tx_q.delete();
      for (int i = 0; i < lens[t % 4]; i++) add_byte(8'($urandom));
      add_fcs(model_crc(tx_q.size()) ^ ((t >= 4) ? 32'h0000_0100 : 32'h0));
      drive_frame(-1, 1 + (t % 2));
    end
    wait_drain(to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL random_drain: got pending=%0d, required 0", exp_q.size() + verd_q.size());
    end
  endtask

  // 8200 dibits with a correct FCS. The length counter saturates at 8191,
  // which is not a whole number of bytes, so the verdict must be bad.
  task automatic test_saturation();
    bit to;
    tx_q.delete();
    for (int i = 0; i < 2046; i++) add_byte(8'($urandom));
    add_fcs(model_crc(tx_q.size()));
    drive_frame(0, 2);
    wait_drain(to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL saturation_drain: got pending=%0d, required 0", exp_q.size() + verd_q.size());
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    build_good();
    for (int j = 0; j < 8; j++) exp_q.push_back(tx_q[j]);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      axiiv = 1'b1;
      axiid = tx_q[j];
    end
    @(negedge clk);
    axiid = tx_q[24];
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({axiov, axiod, done, ok} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got %b, required 00000", {axiov, axiod, done, ok});
    end
    exp_good = 0;
    exp_bad  = 0;
    for (int j = 25; j < tx_q.size(); j++) begin
      @(negedge clk);
      rst   = 1'b1;
      axiid = tx_q[j];
    end
    @(negedge clk);
    axiiv = 1'b0;
    axiid = 2'b00;
    repeat (3) @(negedge clk);
    build_good();
    drive_frame(1, 2);
    wait_drain(to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL mid_reset_drain: got pending=%0d, required 0", exp_q.size() + verd_q.size());
    end
`ifdef FCS_CHECK_STATS_EN
    checks++;
    if (good_count !== 16'(exp_good) || bad_count !== 16'(exp_bad)) begin
      errors++;
      $display("[TB] FAIL mid_reset_counts: got %0d/%0d, required %0d/%0d",
               good_count, bad_count, exp_good, exp_bad);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_runt();
    test_misaligned();
    test_back_to_back();
    test_random_frames();
    test_saturation();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fcs_check.md
# fcs_check

Receive-side Ethernet frame check sequence checker for the RMII dibit stream. It sits between the RMII receive deframer and the packet parser. It delays the incoming dibits by 16 so that the trailing 32-bit FCS is stripped from the output. It runs CRC-32 over the forwarded payload and, at end of frame, compares the result against the stripped FCS to report a good/bad verdict.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  system clock, one dibit per cycle max.
- `rst`  in  1  asynchronous, active-low reset.
- `axiiv`  in  1  input valid. High continuously for the whole frame; low between frames.
- `axiid`  in  2  input dibit. `axiid[0]` is the earlier bit on the wire.
- `axiov`  out  1  payload dibit valid.
- `axiod`  out  2  payload dibit, same bit order as `axiid`.
- `done`  out  1  one-cycle pulse at end of every frame.
- `ok`  out  1  verdict, valid only while `done` = 1. 1 = FCS match and aligned length.
- `good_count`  out  16  frames with `ok` = 1. Present only with `FCS_CHECK_STATS_EN`.
- `bad_count`  out  16  frames with `ok` = 0. Present only with `FCS_CHECK_STATS_EN`.

## Operation
- CRC algorithm:
  - Poly 0x04C11DB7, init 0xFFFFFFFF, non-reflected, two bits per step.
  - Per step, `d[0]` is processed first, against register bit 31.
  - Result is the bitwise complement of the register (CRC-32/BZIP2).
- Buffering: a 16-entry dibit shift register plus a 13-bit saturating dibit counter `n`.
- States: IDLE, FILL, STREAM, DISCARD.
- IDLE:
  - `axiiv` = 1 → accept the dibit into the shift register, set `n` = 1, go to FILL.
- FILL:
  - Each accepted dibit is shifted in and increments `n`.
  - When the 16th dibit is accepted → go to STREAM.
  - No output while in FILL.
- STREAM: each accepted dibit j ≥ 16 is shifted in.
  - The oldest entry (dibit j−16) is registered onto `axiod` with `axiov` = 1.
  - That same dibit is fed into the CRC in the same edge.
- End of frame: `axiiv` = 0 seen in FILL or STREAM.
  - Registers `done` = 1 and `ok`.
  - Reinitialises the CRC to 0xFFFFFFFF and sets `n` = 0.
  - Returns to IDLE.
- FCS word F from the 16 buffered dibits d0..d15 (oldest first): F[31−2k] = d_k[0], F[30−2k] = d_k[1].
- `ok` = 1 iff all three hold:
  - F equals the complemented CRC.
  - `n` ≥ 16.
  - `n[1:0]` = 0 (whole bytes).
- Runt: end of frame in FILL → `done` = 1, `ok` = 0, no payload ever emitted.
- Counter `n` saturates at 8191. A saturated frame still gets a verdict, and its alignment check uses the saturated value.
- Reset deasserted while `axiiv` = 1 → enter DISCARD.
  - Ignore input until `axiiv` = 0, then go to IDLE.
  - No `done` for the partial frame.

## Timing
- Reset values: `axiov`, `axiod`, `done`, `ok` = 0; state IDLE; CRC = 0xFFFFFFFF; counters 0.
- Latency:
  - Input dibit j accepted at edge t → payload dibit j−16 visible on `axiod` after edge t.
  - So each payload dibit leaves 16 accepted dibits after it entered.
- `axiov` is never high in a cycle where `done` = 1.
- `done` pulses in the cycle immediately after the last `axiov` = 1 cycle.
- Back-to-back frames: the minimum gap is one `axiiv` = 0 cycle.
  - The new frame's first dibit may arrive in the cycle that `done` is high.
  - It must not be corrupted by the CRC reinitialisation.
- Asynchronous reset mid-frame:
  - Outputs clear immediately.
  - The next frame starts clean after the DISCARD rule above.

## Configuration
- `FCS_CHECK_STATS_EN` defined:
  - Adds `good_count` and `bad_count`.
  - Each increments on the `done` edge according to `ok`.
  - Both saturate at 0xFFFF and reset to 0.
- `FCS_CHECK_STATS_EN` undefined:
  - Ports and counters are absent.
  - All other behaviour is identical.

## Test plan
- Good frame:
  - Stimulus: ASCII "123456789" (bytes MSB-first, `axiid[0]` = bit 7 then bit 5, …), then FCS 0xFC891918 sent bit 31 first.
  - Response: 36 payload dibits out, equal to the input, with 16-dibit latency; `done` = 1, `ok` = 1.
- Corrupted FCS: same frame with last FCS dibit flipped → identical payload output; `done` = 1, `ok` = 0.
- Runt: 10 dibits then `axiiv` = 0 → no `axiov`; `done` = 1, `ok` = 0 one cycle later.
- Misaligned frame: good frame plus one extra dibit inserted before the FCS → `ok` = 0.
- Back-to-back:
  - Stimulus: two good frames separated by one idle cycle.
  - Response: two `done` pulses, both `ok` = 1; the second frame's payload is exact.
- Mid-frame reset:
  - Stimulus: pulse `rst` low during STREAM while `axiiv` stays high, then send a good frame.
  - Response: no `done` for the interrupted frame; the next frame gives `ok` = 1.
  - With `FCS_CHECK_STATS_EN`: `good_count` = 1.
